filtro_sensores: RTL and testbench

- Input conditioning stage placed directly upstream of the fertigation/cleaning controller.
- Synchronises and debounces the raw field switches (upper level, lower level, fertiliser request, sprinkler request) before the controller's FSM sees them.
- Supervises the two tank-level switches for a physically impossible combination (upper wet, lower dry) and raises a sticky fault.
- Publishes a valid flag once filtered data is trustworthy after reset.

---
 rtl/filtro_sensores_pkg.sv | 27 ++
 rtl/debounce_canal.sv | 61 ++++++
 rtl/filtro_sensores.sv | 122 ++++++++++++
 tb/tb_filtro_sensores.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filtro_sensores_pkg.sv
// Shared definitions for the sensor input-conditioning stage:
// supervisor states, default filter lengths, counter widths, channel map.
package filtro_sensores_pkg;

   // Supervisor states; 2'b11 is unused and recovers to INIT
   typedef enum logic [1:0] {
      INIT  = 2'b00,
      RUN   = 2'b01,
      FAULT = 2'b10
   } estado_t;

   // Default filter lengths
   localparam int DEB_CYCLES_DEF   = 8;
   localparam int FAULT_CYCLES_DEF = 16;

   // Counter widths: debounce counters, startup/fault counters
   localparam int DEB_W = 4;
   localparam int CNT_W = 5;

   // Channel positions inside the packed raw/filtered vectors
   localparam int NUM_CANALES = 4;
   localparam int CH_NV0      = 0;
   localparam int CH_NV1      = 1;
   localparam int CH_ADUB     = 2;
   localparam int CH_ASP      = 3;

endpackage

// File: rtl/debounce_canal.sv
// One conditioned input: two-flop synchroniser followed by a debouncer that
// only accepts a new level after DEB_CYCLES consecutive disagreeing samples.
module debounce_canal
   import filtro_sensores_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic q
);

   localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             q_reg;
   logic             q_next;
   logic [DEB_W-1:0] cnt_reg;
   logic [DEB_W-1:0] cnt_next;

   // Bring the asynchronous switch into the clk domain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
      end
   end

   // Count consecutive disagreements; any agreement restarts the count
   always_comb begin
      q_next   = q_reg;
      cnt_next = '0;
      if (sync2_reg != q_reg) begin
         if (cnt_reg == CNT_LAST) begin
            q_next   = sync2_reg;
            cnt_next = '0;
         end else begin
            cnt_next = cnt_reg + 1'b1;
         end
      end
   end

   // Stable value and debounce counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_reg   <= 1'b0;
         cnt_reg <= '0;
      end else begin
         q_reg   <= q_next;
         cnt_reg <= cnt_next;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/filtro_sensores.sv
// Input conditioning ahead of the fertigation/cleaning controller: debounces
// the four field switches, waits for the filters to settle before flagging
// valid, and latches a fault when the tank switches read upper-wet/lower-dry.
module filtro_sensores
   import filtro_sensores_pkg::*;
#(
   parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
   parameter int FAULT_CYCLES = FAULT_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic nv1_raw,
   input  logic nv0_raw,
   input  logic adub_raw,
   input  logic asp_raw,
   input  logic fault_clr,
   output logic Nv1,
   output logic Nv0,
   output logic Adub,
   output logic Asp,
   output logic valid,
   output logic fault
);

   // Startup wait ends once every debouncer has had time to settle
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] FAULT_LAST = CNT_W'(FAULT_CYCLES - 1);

   logic [NUM_CANALES-1:0] raw_vec;
   logic [NUM_CANALES-1:0] filt_vec;
   logic                   incons;

   estado_t                state_reg;
   logic [CNT_W-1:0]       start_cnt_reg;
   logic [CNT_W-1:0]       fault_cnt_reg;
   logic                   valid_reg;
   logic                   fault_reg;

   assign raw_vec[CH_NV0]  = nv0_raw;
   assign raw_vec[CH_NV1]  = nv1_raw;
   assign raw_vec[CH_ADUB] = adub_raw;
   assign raw_vec[CH_ASP]  = asp_raw;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CANALES; gi++) begin : g_canal
         debounce_canal #(
            .DEB_CYCLES (DEB_CYCLES)
         ) u_canal (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_vec[gi]),
            .q     (filt_vec[gi])
         );
      end
   endgenerate

   // Upper switch wet while lower switch dry cannot happen physically
   assign incons = filt_vec[CH_NV1] & ~filt_vec[CH_NV0];

   // Supervisor: startup settle, inconsistency watch, sticky fault
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= INIT;
         start_cnt_reg <= '0;
         fault_cnt_reg <= '0;
         valid_reg     <= 1'b0;
         fault_reg     <= 1'b0;
      end else begin
         case (state_reg)
            INIT: begin
               fault_cnt_reg <= '0;
               if (start_cnt_reg == START_LAST) begin
                  state_reg     <= RUN;
                  start_cnt_reg <= '0;
                  valid_reg     <= 1'b1;
               end else begin
                  start_cnt_reg <= start_cnt_reg + 1'b1;
               end
            end
            RUN: begin
               if (incons) begin
                  if (fault_cnt_reg == FAULT_LAST) begin
                     state_reg     <= FAULT;
                     fault_cnt_reg <= '0;
                     valid_reg     <= 1'b0;
                     fault_reg     <= 1'b1;
                  end else begin
                     fault_cnt_reg <= fault_cnt_reg + 1'b1;
                  end
               end else begin
                  fault_cnt_reg <= '0;
               end
            end
            FAULT: begin
               // Acknowledge only takes effect once the switches agree again
               if (fault_clr && !incons) begin
                  state_reg     <= INIT;
                  start_cnt_reg <= '0;
                  fault_cnt_reg <= '0;
                  fault_reg     <= 1'b0;
               end
            end
            default: begin
               state_reg     <= INIT;
               start_cnt_reg <= '0;
               fault_cnt_reg <= '0;
               valid_reg     <= 1'b0;
               fault_reg     <= 1'b0;
            end
         endcase
      end
   end

   assign Nv0   = filt_vec[CH_NV0];
   assign Nv1   = filt_vec[CH_NV1];
   assign Adub  = filt_vec[CH_ADUB];
   assign Asp   = filt_vec[CH_ASP];
   assign valid = valid_reg;
   assign fault = fault_reg;

endmodule

// File: tb/tb_filtro_sensores.sv
// Self-checking bench for filtro_sensores: directed steps from the test plan
// followed by randomized switch activity, all compared against a window-based
// behavioural model of the filters and supervisor.
module tb_filtro_sensores;

   localparam int DEB = 8;
   localparam int FLT = 16;

   localparam int PH_ARRANQUE = 0;
   localparam int PH_MARCHA   = 1;
   localparam int PH_AVERIA   = 2;

   logic clk = 1'b0;
   logic reset;
   logic nv1_raw, nv0_raw, adub_raw, asp_raw, fault_clr;
   logic Nv1, Nv0, Adub, Asp, valid, fault;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [3:0] raw_hist[$];
   logic [3:0] s_hist[$];
   logic [3:0] m_q;
   int         ph;
   int         edges_in_init;
   int         incons_run;

   filtro_sensores #(
      .DEB_CYCLES   (DEB),
      .FAULT_CYCLES (FLT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .nv1_raw   (nv1_raw),
      .nv0_raw   (nv0_raw),
      .adub_raw  (adub_raw),
      .asp_raw   (asp_raw),
      .fault_clr (fault_clr),
      .Nv1       (Nv1),
      .Nv0       (Nv0),
      .Adub      (Adub),
      .Asp       (Asp),
      .valid     (valid),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      raw_hist.delete();
      s_hist.delete();
      m_q           = '0;
      ph            = PH_ARRANQUE;
      edges_in_init = 0;
      incons_run    = 0;
   endtask

   // One rising edge of the model: supervisor sees pre-edge filtered values;
   // a filtered bit flips when the last DEB synchronised samples all oppose it
   task automatic model_edge();
      logic [3:0] cur;
      logic [3:0] s_now;
      logic       incons;
      bit         all_opp;
      incons = m_q[1] & ~m_q[0];
      case (ph)
         PH_ARRANQUE: begin
            edges_in_init++;
            if (edges_in_init == DEB + 2) begin
               ph         = PH_MARCHA;
               incons_run = 0;
            end
         end
         PH_MARCHA: begin
            if (incons) begin
               incons_run++;
               if (incons_run == FLT) ph = PH_AVERIA;
            end else begin
               incons_run = 0;
            end
         end
         default: begin
            if (fault_clr && !incons) begin
               ph            = PH_ARRANQUE;
               edges_in_init = 0;
            end
         end
      endcase
      cur = {asp_raw, adub_raw, nv1_raw, nv0_raw};
      raw_hist.push_back(cur);
      s_now = (raw_hist.size() >= 3) ? raw_hist[raw_hist.size() - 3] : 4'b0000;
      s_hist.push_back(s_now);
      for (int ch = 0; ch < 4; ch++) begin
         if (s_hist.size() >= DEB) begin
            all_opp = 1'b1;
            for (int k = 1; k <= DEB; k++)
               if (s_hist[s_hist.size() - k][ch] == m_q[ch]) all_opp = 1'b0;
            if (all_opp) m_q[ch] = ~m_q[ch];
         end
      end
      while (raw_hist.size() > 40) void'(raw_hist.pop_front());
      while (s_hist.size() > 40) void'(s_hist.pop_front());
   endtask

   task automatic check_all();
      chk("Nv0",   Nv0,   m_q[0]);
      chk("Nv1",   Nv1,   m_q[1]);
      chk("Adub",  Adub,  m_q[2]);
      chk("Asp",   Asp,   m_q[3]);
      chk("valid", valid, logic'(ph == PH_MARCHA));
      chk("fault", fault, logic'(ph == PH_AVERIA));
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) model_edge();
      #1;
      check_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic logic get_out(input int sel);
      case (sel)
         0:       return Nv0;
         1:       return Nv1;
         2:       return valid;
         default: return fault;
      endcase
   endfunction

   // Bounded wait: number of edges until the selected output reaches val
   task automatic count_until(input int sel, input logic val, output int n);
      n = -1;
      for (int i = 1; i <= 40 && n < 0; i++) begin
         step();
         if (get_out(sel) === val) n = i;
      end
   endtask

   initial begin
      int   n;
      logic seen;

      // Reset held with all switches active: everything must read 0
      reset = 1'b0; nv1_raw = 1'b1; nv0_raw = 1'b1; adub_raw = 1'b1; asp_raw = 1'b1;
      fault_clr = 1'b0;
      model_reset();
      #1;
      steps(4);
      $display("tx reset_hold   outputs=%b%b%b%b valid=%b fault=%b", Nv1, Nv0, Adub, Asp, valid, fault);

      // Startup: outputs and valid rise together on edge DEB+2
      reset = 1'b1;
      count_until(2, 1'b1, n);
      chk_int("startup_valid_edge", n, DEB + 2);
      chk("startup_Nv1", Nv1, 1'b1);
      chk("startup_Asp", Asp, 1'b1);
      chk("startup_fault", fault, 1'b0);
      $display("tx startup     valid_edge=%0d", n);

      // All switches off, then a 5-cycle glitch on nv0_raw
      nv1_raw = 1'b0; nv0_raw = 1'b0; adub_raw = 1'b0; asp_raw = 1'b0;
      steps(12);
      nv0_raw = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin step(); seen |= Nv0; end
      nv0_raw = 1'b0;
      for (int i = 0; i < 12; i++) begin step(); seen |= Nv0; end
      chk("glitch_rejected", seen, 1'b0);
      nv0_raw = 1'b1;
      count_until(0, 1'b1, n);
      chk_int("nv0_step_edge", n, DEB + 2);
      $display("tx glitch      nv0_seen=%b step_edge=%0d", seen, n);

      // Bounce on nv1_raw: count restarts from the second rise
      nv1_raw = 1'b1; steps(6);
      nv1_raw = 1'b0; steps(1);
      nv1_raw = 1'b1;
      count_until(1, 1'b1, n);
      chk_int("bounce_restart_edge", n, DEB + 2);
      $display("tx bounce      nv1_edge=%0d", n);

      // Inconsistency held 15 cycles: no fault
      nv0_raw = 1'b0;
      count_until(0, 1'b0, n);
      chk_int("nv0_fall_edge", n, DEB + 2);
      steps(FLT - 1 - DEB - 2 + DEB + 2 - n + 0);
      nv0_raw = 1'b1;
      steps(12);
      chk("incons_15_no_fault", fault, 1'b0);
      chk("incons_15_valid", valid, 1'b1);
      $display("tx incons15    fault=%b", fault);

      // Inconsistency held 16 cycles: fault on the 16th edge
      nv0_raw = 1'b0;
      steps(FLT);
      nv0_raw = 1'b1;
      count_until(3, 1'b1, n);
      chk_int("fault_edge", n, DEB + 2);
      chk("fault_valid_low", valid, 1'b0);
      $display("tx incons16    fault_edge_after_raise=%0d", n);

      // Acknowledge while still inconsistent: fault stays
      nv0_raw = 1'b0;
      steps(12);
      fault_clr = 1'b1;
      steps(3);
      chk("clr_while_incons", fault, 1'b1);
      fault_clr = 1'b0;
      nv0_raw = 1'b1;
      steps(12);
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      chk("clr_fault_low", fault, 1'b0);
      chk("clr_valid_low", valid, 1'b0);
      count_until(2, 1'b1, n);
      chk_int("clr_valid_edge", n, DEB + 2);
      $display("tx fault_clear valid_edge=%0d", n);

      // Async reset while nv1 debounce count sits at 5
      nv1_raw = 1'b0;
      steps(7);
      chk("pre_reset_Nv1", Nv1, 1'b1);
      #2 reset = 1'b0;
      model_reset();
      #1;
      chk("async_Nv1", Nv1, 1'b0);
      chk("async_valid", valid, 1'b0);
      check_all();
      steps(3);
      #2 reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin step(); seen |= Nv1; end
      chk("no_stale_Nv1", seen, 1'b0);
      $display("tx async_reset stale_nv1=%b valid=%b", seen, valid);

      // Randomized switch activity with occasional acknowledges and resets
      for (int seg = 0; seg < 80; seg++) begin
         logic [3:0] r;
         int         len;
         r = 4'($urandom);
         if ($urandom_range(0, 2) == 0) r[1:0] = 2'b10;
         {asp_raw, adub_raw, nv1_raw, nv0_raw} = r;
         fault_clr = ($urandom_range(0, 3) == 0);
         len = $urandom_range(1, 24);
         if ($urandom_range(0, 19) == 0) begin
            #2 reset = 1'b0;
            model_reset();
            #1 check_all();
            steps(2);
            #2 reset = 1'b1;
         end
         steps(len);
         $display("tx random %0d raw=%b clr=%b len=%0d out=%b%b%b%b valid=%b fault=%b",
                  seg, r, fault_clr, len, Nv1, Nv0, Adub, Asp, valid, fault);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
